// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multicycle memory between I-cache line fills and D-cache fills/stores.
// Reads stream LINE_WORDS words from the line base; stores are a single write; ties alternate.
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              i_stall,
    output logic              i_cache_we,
    output logic [ADDR_W-1:0] i_addr_out,
    output logic [DATA_W-1:0] i_data_out,
    output logic              d_stall,
    output logic              d_cache_we,
    output logic [ADDR_W-1:0] d_addr_out,
    output logic [DATA_W-1:0] d_data_out
);
    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, I_ISSUE, I_WAIT, D_ISSUE, D_WAIT, W_ISSUE, W_WAIT} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [DATA_W-1:0] wdata, wdata_nx;
    logic              last_grant, last_grant_nx;
    logic              last_word, issue, grant_d, grant_i;
    logic [ADDR_W-1:0] fill_addr;

    assign last_word = cnt == CW'(LINE_WORDS - 1);
    assign fill_addr = base + (ADDR_W'(cnt) << 1);
    // last_grant: 0 = I, 1 = D; on a tie the other side wins
    assign grant_d   = d_req & (~i_req | ~last_grant);
    assign grant_i   = i_req & ~grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            base       <= '0;
            wdata      <= '0;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            base       <= base_nx;
            wdata      <= wdata_nx;
            last_grant <= last_grant_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        base_nx       = base;
        wdata_nx      = wdata;
        last_grant_nx = last_grant;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx      = d_write ? W_ISSUE : D_ISSUE;
                    last_grant_nx = 1'b1;
                    base_nx       = d_write ? d_addr : d_addr & LINE_MASK;
                    wdata_nx      = d_write ? d_wdata : wdata;
                    cnt_nx        = '0;
                end else if (grant_i) begin
                    state_nx      = I_ISSUE;
                    last_grant_nx = 1'b0;
                    base_nx       = i_addr & LINE_MASK;
                    cnt_nx        = '0;
                end
            end
            I_ISSUE: state_nx = I_WAIT;
            D_ISSUE: state_nx = D_WAIT;
            W_ISSUE: state_nx = W_WAIT;
            I_WAIT, D_WAIT: begin
                if (mem_valid) begin
                    cnt_nx   = last_word ? '0 : cnt + 1'b1;
                    state_nx = last_word ? IDLE : (state == I_WAIT ? I_ISSUE : D_ISSUE);
                end
            end
            W_WAIT: state_nx = mem_valid ? IDLE : W_WAIT;
            default: state_nx = IDLE;
        endcase
    end

    assign issue     = state inside {I_ISSUE, D_ISSUE, W_ISSUE};
    assign mem_req   = issue;
    assign mem_wr    = state == W_ISSUE;
    assign mem_addr  = !issue ? '0 : (mem_wr ? base : fill_addr);
    assign mem_wdata = mem_wr ? wdata : '0;

    assign i_cache_we = state == I_WAIT && mem_valid;
    assign i_addr_out = i_cache_we ? fill_addr : '0;
    assign i_data_out = i_cache_we ? mem_rdata : '0;
    assign d_cache_we = state == D_WAIT && mem_valid;
    assign d_addr_out = d_cache_we ? fill_addr : '0;
    assign d_data_out = d_cache_we ? mem_rdata : '0;

    assign i_stall = i_req & ~(i_cache_we & last_word);
    assign d_stall = d_req & ~((d_cache_we & last_word) | (state == W_WAIT && mem_valid));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-by-cycle checks of mem_arbiter against a fixed-latency memory.
module tb_mem_arbiter;
    logic        clk = 0, rst = 0;
    logic        i_req = 0, d_req = 0, d_write = 0, mem_valid = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        mem_req, mem_wr, i_stall, i_cache_we, d_stall, d_cache_we;
    logic [15:0] mem_addr, mem_wdata, i_addr_out, i_data_out, d_addr_out, d_data_out;
    logic [101:0] all_out;
    int tests = 0, fails = 0, lat = 2;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_write(d_write),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .i_stall(i_stall),
        .i_cache_we(i_cache_we), .i_addr_out(i_addr_out), .i_data_out(i_data_out), .d_stall(d_stall),
        .d_cache_we(d_cache_we), .d_addr_out(d_addr_out), .d_data_out(d_data_out)
    );

    assign all_out = {mem_req, mem_wr, mem_addr, mem_wdata, i_stall, i_cache_we, i_addr_out, i_data_out,
                      d_stall, d_cache_we, d_addr_out, d_data_out};

    always #5 clk = ~clk;

    function automatic logic [15:0] rd(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Expected fill activity k cycles after the first issue: 4 words, each issue + lat wait cycles
    function automatic void fill_exp(input int k, input int per, input logic [15:0] b,
                                     output logic req, output logic we, output logic [15:0] a);
        req = 0; we = 0; a = 0;
        if (k >= 0 && k < 4 * per) begin
            a   = b + 16'(2 * (k / per));
            req = (k % per) == 0;
            we  = (k % per) == per - 1;
        end
    endfunction

    // Memory model: answers each accepted mem_req exactly lat cycles later
    initial begin
        logic [15:0] a;
        logic        w;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                a = mem_addr;
                w = mem_wr;
                repeat (lat) @(posedge clk);
                #1 mem_valid = 1; mem_rdata = w ? 16'h0 : rd(a);
                @(posedge clk);
                #1 mem_valid = 0; mem_rdata = 0;
            end
        end
    end

    task automatic run_until_clear(output logic [15:0] first, output logic d_first, output logic timeout);
        logic got, fin, dd, di;
        got = 0; fin = 0; first = 0; d_first = 0; timeout = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (mem_req && !got) begin first = mem_addr; got = 1; end
            dd = d_req && !d_stall;
            di = i_req && !i_stall;
            if ((dd || di) && !fin) begin d_first = dd; fin = 1; end
            @(posedge clk); #1;
            if (dd) d_req = 0;
            if (di) i_req = 0;
            if (!i_req && !d_req) begin timeout = 0; break; end
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_hold got=%h exp=0", all_out); end
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_release got=%h exp=0", all_out); end
    endtask

    task automatic test_tie_after_reset;
        logic [85:0] obs, want;
        logic dr, dwe, ir, iwe;
        logic [15:0] da, ia;
        @(posedge clk); #1;
        lat = 2; i_addr = 16'h0036; d_addr = 16'h2005; d_write = 0; i_req = 1; d_req = 1;
        for (int cy = 0; cy <= 26; cy++) begin
            @(negedge clk);
            fill_exp(cy - 1, 3, 16'h2000, dr, dwe, da);
            fill_exp(cy - 14, 3, 16'h0030, ir, iwe, ia);
            obs  = {mem_req, mem_wr, mem_addr, d_cache_we, d_addr_out, d_data_out,
                    i_cache_we, i_addr_out, i_data_out, i_stall, d_stall};
            want = {dr | ir, 1'b0, dr ? da : (ir ? ia : 16'h0), dwe, dwe ? da : 16'h0, dwe ? rd(da) : 16'h0,
                    iwe, iwe ? ia : 16'h0, iwe ? rd(ia) : 16'h0, cy < 25, cy < 12};
            tests++;
            if (obs !== want) begin fails++; $display("FAIL tie_reset cy=%0d got=%h exp=%h", cy, obs, want); end
            @(posedge clk); #1;
            if (cy == 12) d_req = 0;
            if (cy == 25) i_req = 0;
        end
    endtask

    task automatic test_i_fill;
        logic [69:0] obs, want;
        logic ir, iwe;
        logic [15:0] ia;
        @(posedge clk); #1;
        lat = 4; i_addr = 16'h0036; i_req = 1;
        for (int cy = 0; cy <= 21; cy++) begin
            @(negedge clk);
            fill_exp(cy - 1, 5, 16'h0030, ir, iwe, ia);
            obs  = {mem_req, mem_wr, mem_addr, mem_wdata, i_cache_we, i_addr_out, i_data_out, i_stall, d_cache_we, d_stall};
            want = {ir, 1'b0, ir ? ia : 16'h0, 16'h0, iwe, iwe ? ia : 16'h0, iwe ? rd(ia) : 16'h0, cy < 20, 1'b0, 1'b0};
            tests++;
            if (obs !== want) begin fails++; $display("FAIL i_fill cy=%0d got=%h exp=%h", cy, obs, want); end
            @(posedge clk); #1;
            if (cy == 20) i_req = 0;
        end
    endtask

    task automatic test_second_tie;
        logic [15:0] first;
        logic d_first, timeout;
        @(posedge clk); #1;
        lat = 2; i_addr = 16'h0104; d_addr = 16'h020A; d_write = 0; i_req = 1; d_req = 1;
        run_until_clear(first, d_first, timeout);
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL tie_after_i_timeout got=%b exp=0", timeout); end
        tests++;
        if (first !== 16'h0208) begin fails++; $display("FAIL tie_after_i_first got=%h exp=0208", first); end
        tests++;
        if (d_first !== 1'b1) begin fails++; $display("FAIL tie_after_i_order got=%b exp=1", d_first); end
    endtask

    task automatic test_store;
        logic [51:0] obs, want;
        @(posedge clk); #1;
        lat = 2; d_write = 1; d_addr = 16'h1002; d_wdata = 16'hBEEF; d_req = 1;
        for (int cy = 0; cy <= 4; cy++) begin
            @(negedge clk);
            obs  = {mem_req, mem_wr, mem_addr, mem_wdata, d_cache_we, d_addr_out, d_stall};
            want = {cy == 1, cy == 1, cy == 1 ? 16'h1002 : 16'h0, cy == 1 ? 16'hBEEF : 16'h0, 1'b0, 16'h0, cy < 3};
            tests++;
            if (obs !== want) begin fails++; $display("FAIL store cy=%0d got=%h exp=%h", cy, obs, want); end
            @(posedge clk); #1;
            if (cy == 3) begin d_req = 0; d_write = 0; end
        end
    endtask

    task automatic test_tie_after_d;
        logic [15:0] first;
        logic d_first, timeout;
        @(posedge clk); #1;
        lat = 2; i_addr = 16'h0042; d_addr = 16'h0300; d_write = 0; i_req = 1; d_req = 1;
        run_until_clear(first, d_first, timeout);
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL tie_after_d_timeout got=%b exp=0", timeout); end
        tests++;
        if (first !== 16'h0040) begin fails++; $display("FAIL tie_after_d_first got=%h exp=0040", first); end
        tests++;
        if (d_first !== 1'b0) begin fails++; $display("FAIL tie_after_d_order got=%b exp=0", d_first); end
    endtask

    task automatic test_req_drop;
        logic [49:0] obs, want;
        logic dr, dwe;
        logic [15:0] da;
        @(posedge clk); #1;
        lat = 2; d_addr = 16'h3006; d_write = 0; d_req = 1;
        for (int cy = 0; cy <= 13; cy++) begin
            @(negedge clk);
            fill_exp(cy - 1, 3, 16'h3000, dr, dwe, da);
            obs  = {mem_req, mem_addr, d_cache_we, d_addr_out, d_data_out, d_stall};
            want = {dr, dr ? da : 16'h0, dwe, dwe ? da : 16'h0, dwe ? rd(da) : 16'h0, cy < 5};
            tests++;
            if (obs !== want) begin fails++; $display("FAIL req_drop cy=%0d got=%h exp=%h", cy, obs, want); end
            @(posedge clk); #1;
            if (cy == 4) begin d_req = 0; d_addr = 16'hFFFF; end
        end
    endtask

    task automatic test_reset_mid_fill;
        @(posedge clk); #1;
        lat = 4; i_addr = 16'h0040; i_req = 1;
        for (int cy = 0; cy <= 18; cy++) begin
            @(negedge clk);
            if (cy == 11) begin
                tests++;
                if ({mem_req, mem_addr} !== {1'b1, 16'h0044}) begin
                    fails++; $display("FAIL mid_fill_third_issue got=%h exp=10044", {mem_req, mem_addr});
                end
            end
            if (cy >= 13) begin
                tests++;
                if (all_out !== '0) begin fails++; $display("FAIL mid_fill_reset cy=%0d got=%h exp=0", cy, all_out); end
            end
            @(posedge clk); #1;
            if (cy == 12) begin rst = 0; i_req = 0; end
            if (cy == 13) rst = 1;
        end
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_tie_after_reset;
        test_i_fill;
        test_second_tie;
        test_store;
        test_tie_after_d;
        test_req_drop;
        test_reset_mid_fill;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
